// File: rtl/sid_osc_bank_pkg.sv
// Shared constants for the SID oscillator bank: control-byte bit positions,
// LFSR seed and the LFSR taps that form the noise waveform.
package sid_pkg;

  localparam int CTRL_SYNC  = 1;
  localparam int CTRL_RING  = 2;
  localparam int CTRL_TEST  = 3;
  localparam int CTRL_TRI   = 4;
  localparam int CTRL_SAW   = 5;
  localparam int CTRL_PULSE = 6;
  localparam int CTRL_NOISE = 7;

  localparam logic [22:0] LFSR_SEED = 23'h7FFFF8;

  // Taps listed from the noise output MSB downward.
  localparam int NOISE_TAP_N = 8;
  localparam int NOISE_TAPS [0:NOISE_TAP_N-1] = '{22, 20, 16, 13, 11, 7, 4, 2};

endpackage

// File: rtl/sid_osc_bank_if.sv
// Register-file side bundle of the oscillator bank: tick, per-voice settings
// in, per-voice waveforms and accumulator MSBs out.
interface sid_osc_bank_if #(
  parameter int NUM_VOICES = 3,
  parameter int FREQ_W     = 16,
  parameter int OUT_W      = 12
);
  logic                          clk_en;
  logic [NUM_VOICES*FREQ_W-1:0]  i_freq;
  logic [NUM_VOICES*OUT_W-1:0]   i_pw;
  logic [NUM_VOICES*8-1:0]       i_ctrl;
  logic [NUM_VOICES*OUT_W-1:0]   o_wave;
  logic [NUM_VOICES-1:0]         o_msb;

  modport master (
    output clk_en, i_freq, i_pw, i_ctrl,
    input  o_wave, o_msb
  );

  modport slave (
    input  clk_en, i_freq, i_pw, i_ctrl,
    output o_wave, o_msb
  );
endinterface

// File: rtl/sid_osc_bank_voice.sv
// One SID voice: phase accumulator, noise LFSR, sync/ring from a source voice,
// and registered AND-combination of the enabled waveforms.
module sid_osc_voice
  import sid_pkg::*;
#(
  parameter int ACC_W  = 24,
  parameter int FREQ_W = 16,
  parameter int OUT_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [FREQ_W-1:0] freq,
  input  logic [OUT_W-1:0]  pw,
  input  logic [7:0]        ctrl,
  input  logic              src_msb,
  input  logic              src_msb_rise,
  output logic              msb,
  output logic              msb_rise,
  output logic [OUT_W-1:0]  wave,
  output logic              wave_msb
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [22:0]      lfsr_q, lfsr_d;
  logic             prev_msb_q, prev_msb_d;
  logic             prev_nbit_q, prev_nbit_d;
  logic [OUT_W-1:0] wave_q, wave_d;
  logic             wave_msb_q, wave_msb_d;

  logic             nbit_rise;
  logic [OUT_W-1:0] saw_w, tri_w, pulse_w, noise_w;
  logic [NOISE_TAP_N-1:0] noise_bits;
  logic             tri_invert;
  logic             any_en;
  logic             ctrl_unused;

  assign ctrl_unused = ctrl[0];

  assign msb       = acc_q[ACC_W-1];
  assign msb_rise  = acc_q[ACC_W-1] & ~prev_msb_q;
  assign nbit_rise = acc_q[ACC_W-5] & ~prev_nbit_q;

  always_comb begin
    acc_d       = acc_q;
    lfsr_d      = lfsr_q;
    prev_msb_d  = prev_msb_q;
    prev_nbit_d = prev_nbit_q;
    if (clk_en) begin
      prev_msb_d  = acc_q[ACC_W-1];
      prev_nbit_d = acc_q[ACC_W-5];
      if (ctrl[CTRL_TEST]) begin
        acc_d  = '0;
        lfsr_d = LFSR_SEED;
      end else begin
        // Sync uses the source's registered edge, so it lands one tick after the rise.
        if (ctrl[CTRL_SYNC] && src_msb_rise) begin
          acc_d = '0;
        end else begin
          acc_d = acc_q + {{(ACC_W-FREQ_W){1'b0}}, freq};
        end
        if (nbit_rise) begin
          lfsr_d = {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]};
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NOISE_TAP_N; gi++) begin : g_noise_tap
      assign noise_bits[NOISE_TAP_N-1-gi] = lfsr_q[NOISE_TAPS[gi]];
    end
  endgenerate

  assign saw_w      = acc_q[ACC_W-1 -: OUT_W];
  assign tri_invert = acc_q[ACC_W-1] ^ (ctrl[CTRL_RING] & src_msb);
  assign tri_w      = {acc_q[ACC_W-2 -: OUT_W-1] ^ {(OUT_W-1){tri_invert}}, 1'b0};
  assign pulse_w    = (ctrl[CTRL_TEST] || (saw_w >= pw)) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
  assign noise_w    = OUT_W'(noise_bits) << (OUT_W - NOISE_TAP_N);

  always_comb begin
    wave_d = {OUT_W{1'b1}};
    any_en = 1'b0;
    if (ctrl[CTRL_TRI]) begin
      wave_d = wave_d & tri_w;
      any_en = 1'b1;
    end
    if (ctrl[CTRL_SAW]) begin
      wave_d = wave_d & saw_w;
      any_en = 1'b1;
    end
    if (ctrl[CTRL_PULSE]) begin
      wave_d = wave_d & pulse_w;
      any_en = 1'b1;
    end
    if (ctrl[CTRL_NOISE]) begin
      wave_d = wave_d & noise_w;
      any_en = 1'b1;
    end
    if (!any_en) begin
      wave_d = '0;
    end
    wave_msb_d = acc_q[ACC_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      prev_msb_q  <= 1'b0;
      prev_nbit_q <= 1'b0;
      wave_q      <= '0;
      wave_msb_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      lfsr_q      <= lfsr_d;
      prev_msb_q  <= prev_msb_d;
      prev_nbit_q <= prev_nbit_d;
      wave_q      <= wave_d;
      wave_msb_q  <= wave_msb_d;
    end
  end

  assign wave     = wave_q;
  assign wave_msb = wave_msb_q;

endmodule

// File: rtl/sid_osc_bank.sv
// Multi-voice SID oscillator bank: NUM_VOICES voices chained in a ring, each
// taking sync/ring from the voice before it.
module sid_osc_bank #(
  parameter int NUM_VOICES = 3,
  parameter int ACC_W      = 24,
  parameter int FREQ_W     = 16,
  parameter int OUT_W      = 12
) (
  input  logic          clk,
  input  logic          rst,
  sid_osc_bank_if.slave bus
);

  logic [NUM_VOICES-1:0] msb_w;
  logic [NUM_VOICES-1:0] msb_rise_w;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      // With a single voice this wraps to itself.
      localparam int SRC = (gi + NUM_VOICES - 1) % NUM_VOICES;

      sid_osc_voice #(
        .ACC_W  (ACC_W),
        .FREQ_W (FREQ_W),
        .OUT_W  (OUT_W)
      ) u_voice (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (bus.clk_en),
        .freq         (bus.i_freq[gi*FREQ_W +: FREQ_W]),
        .pw           (bus.i_pw[gi*OUT_W +: OUT_W]),
        .ctrl         (bus.i_ctrl[gi*8 +: 8]),
        .src_msb      (msb_w[SRC]),
        .src_msb_rise (msb_rise_w[SRC]),
        .msb          (msb_w[gi]),
        .msb_rise     (msb_rise_w[gi]),
        .wave         (bus.o_wave[gi*OUT_W +: OUT_W]),
        .wave_msb     (bus.o_msb[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sid_osc_bank.sv
// Scoreboard bench for sid_osc_bank: directed stimulus pushes hand-computed
// expectations, a monitor pops and compares them against the registered outputs.
module tb_sid_osc_bank;

  localparam int NV = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sid_osc_bank_if #(.NUM_VOICES(NV), .FREQ_W(16), .OUT_W(12)) bus ();

  sid_osc_bank #(.NUM_VOICES(NV), .ACC_W(24), .FREQ_W(16), .OUT_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          kind;   // 0: o_wave of voice idx, 1: o_msb vector
    int          idx;
    logic [11:0] exp;
  } chk_t;

  chk_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int kind, input int idx, input logic [11:0] exp);
    chk_t c;
    c.name = name;
    c.kind = kind;
    c.idx  = idx;
    c.exp  = exp;
    sb_q.push_back(c);
  endtask

  // Monitor: just after each falling edge, compare everything queued for this edge.
  initial begin
    chk_t        c;
    logic [11:0] act;
    forever begin
      @(negedge clk);
      #1;
      while (sb_q.size() > 0) begin
        c = sb_q.pop_front();
        if (c.kind == 0) act = bus.o_wave[c.idx*12 +: 12];
        else             act = {9'b0, bus.o_msb};
        total++;
        if (act !== c.exp) begin
          bad++;
          $display("FAIL %s: got 0x%03h expected 0x%03h", c.name, act, c.exp);
        end else begin
          $display("ok   %s: 0x%03h", c.name, act);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_voice(input int v, input logic [15:0] f, input logic [11:0] p, input logic [7:0] c);
    bus.i_freq[v*16 +: 16] = f;
    bus.i_pw[v*12 +: 12]   = p;
    bus.i_ctrl[v*8 +: 8]   = c;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // One clk_en pulse per two clocks; returns on a falling edge with outputs updated.
  task automatic tick(input int n);
    repeat (n) begin
      bus.clk_en = 1'b1;
      @(negedge clk);
      bus.clk_en = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.clk_en = 1'b0;
    bus.i_freq = '0;
    bus.i_pw   = '0;
    bus.i_ctrl = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.clk_en = 1'b0;
    bus.i_freq = '0;
    bus.i_pw   = '0;
    bus.i_ctrl = '0;
    @(negedge clk);
    do_reset();
    chk("reset_wave0", 0, 0, 12'h000);
    chk("reset_wave1", 0, 1, 12'h000);
    chk("reset_wave2", 0, 2, 12'h000);
    chk("reset_msb",   1, 0, 12'h000);

    // Sawtooth accumulation and wrap
    set_voice(0, 16'h1000, 12'h000, 8'h20);
    tick(256);
    chk("saw_256", 0, 0, 12'h100);
    repeat (5) @(negedge clk);
    chk("saw_hold", 0, 0, 12'h100);
    tick(3840);
    chk("saw_wrap", 0, 0, 12'h000);

    // Test bit, then release
    do_reset();
    set_voice(0, 16'h1000, 12'h000, 8'h48);
    tick(10);
    chk("test_pulse", 0, 0, 12'hFFF);
    chk("test_msb",   1, 0, 12'h000);
    set_voice(0, 16'h1000, 12'h000, 8'h20);
    settle();
    chk("test_acc0", 0, 0, 12'h000);
    tick(16);
    chk("test_release16", 0, 0, 12'h010);
    // Pulse threshold: T=0x010
    set_voice(0, 16'h1000, 12'h010, 8'h40);
    settle();
    chk("pulse_eq_pw", 0, 0, 12'hFFF);
    set_voice(0, 16'h1000, 12'h011, 8'h40);
    settle();
    chk("pulse_lt_pw", 0, 0, 12'h000);
    set_voice(0, 16'h1000, 12'h010, 8'h60);
    settle();
    chk("saw_and_pulse", 0, 0, 12'h010);

    // Hard sync: voice 0 MSB rises at tick 256, voice 1 clears at tick 257
    do_reset();
    set_voice(0, 16'h8000, 12'h000, 8'h00);
    set_voice(1, 16'h0100, 12'h000, 8'h22);
    tick(256);
    chk("sync_before", 0, 1, 12'h010);
    chk("sync_msb",    1, 0, 12'h001);
    tick(1);
    chk("sync_cleared", 0, 1, 12'h000);

    // Ring modulation: voice 1 MSB=1, voice 2 acc=0x010000
    do_reset();
    set_voice(1, 16'h8000, 12'h000, 8'h00);
    set_voice(2, 16'h0100, 12'h000, 8'h10);
    tick(256);
    chk("tri_plain", 0, 2, 12'h020);
    set_voice(2, 16'h0100, 12'h000, 8'h14);
    settle();
    chk("tri_ring", 0, 2, 12'hFDE);
    set_voice(2, 16'h0100, 12'h000, 8'h50);
    settle();
    chk("tri_and_pulse", 0, 2, 12'h020);
    set_voice(2, 16'h0100, 12'h000, 8'h01);
    settle();
    chk("none_enabled", 0, 2, 12'h000);

    // Noise: shifts at ticks 17 and 49
    do_reset();
    set_voice(0, 16'h8000, 12'h000, 8'h80);
    settle();
    chk("noise_seed", 0, 0, 12'hFE0);
    tick(17);
    chk("noise_t17", 0, 0, 12'hFE0);
    tick(31);
    chk("noise_t48", 0, 0, 12'hFE0);
    tick(1);
    chk("noise_t49", 0, 0, 12'hFC0);

    // Reset mid-run with clk_en held high
    do_reset();
    set_voice(0, 16'h1000, 12'h000, 8'h20);
    set_voice(1, 16'h8000, 12'h000, 8'h80);
    tick(100);
    chk("run_saw", 0, 0, 12'h064);
    bus.clk_en = 1'b1;
    rst        = 1'b1;
    @(negedge clk);
    chk("midrst_wave0", 0, 0, 12'h000);
    chk("midrst_wave1", 0, 1, 12'h000);
    chk("midrst_msb",   1, 0, 12'h000);
    rst = 1'b0;
    @(negedge clk);
    bus.clk_en = 1'b0;
    @(negedge clk);
    chk("post_rst_saw",   0, 0, 12'h001);
    chk("post_rst_noise", 0, 1, 12'hFE0);

    @(negedge clk);
    #2;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
